// File: rtl/hilo_if.sv
// Handshake and data bundle between the issue stage and the HI/LO unit.
// The master drives the function code, operands and product; the slave returns HI/LO state.
interface hilo_if #(
  parameter int DATA_W = 32
);
  logic [5:0]          Signal;
  logic                mul_start;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [DATA_W-1:0]   dataOut;
  logic                busy;
  logic                done;
  logic                rd_stall;

  modport master (
    output Signal, mul_start, product, wr_data,
    input  hi, lo, dataOut, busy, done, rd_stall
  );

  modport slave (
    input  Signal, mul_start, product, wr_data,
    output hi, lo, dataOut, busy, done, rd_stall
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register file: sequences MULTU latency, captures the product,
// and serves MFHI/MFLO/MTHI/MTLO with a read stall while a multiply is in flight.
module hilo_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic   clk,
  input  logic   reset,
  hilo_if.slave  bus
);
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPTURE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [DATA_W-1:0] hi_q, hi_n;
  logic [DATA_W-1:0] lo_q, lo_n;
  logic              is_mul;
  logic              rd_hi, rd_lo;

  assign is_mul = (bus.Signal == F_MULTU);
  assign rd_hi  = (bus.Signal == F_MFHI);
  assign rd_lo  = (bus.Signal == F_MFLO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    hi_n    = hi_q;
    lo_n    = lo_q;
    unique case (state)
      IDLE: begin
        if (bus.mul_start && is_mul) begin
          state_n = RUN;
          count_n = '0;
        end else if (bus.Signal == F_MTHI) begin
          hi_n = bus.wr_data;
        end else if (bus.Signal == F_MTLO) begin
          lo_n = bus.wr_data;
        end
      end
      RUN: begin
        // Any non-MULTU code means the op was squashed upstream.
        if (!is_mul) begin
          state_n = IDLE;
          count_n = '0;
        end else begin
          count_n = count + CW'(1);
          if (count == LAST) state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        hi_n    = bus.product[2*DATA_W-1:DATA_W];
        lo_n    = bus.product[DATA_W-1:0];
        count_n = '0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state == RUN) || (state == CAPTURE);
  assign bus.done     = (state == CAPTURE);
  assign bus.rd_stall = bus.busy && (rd_hi || rd_lo);

  always_comb begin
    bus.dataOut = '0;
    unique case (1'b1)
      rd_hi:   bus.dataOut = hi_q;
      rd_lo:   bus.dataOut = lo_q;
      default: bus.dataOut = '0;
    endcase
  end
endmodule

// File: tb/tb_hilo_unit.sv
// Directed and randomized bench for hilo_unit against an edge-timeline reference model.
module tb_hilo_unit;
  localparam int MC = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_seen;

  hilo_if #(.DATA_W(32)) b ();

  hilo_unit #(.DATA_W(32), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_hi, m_lo;
  logic        m_act;
  int          m_start;
  int          cyc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: a MULTU started at edge S captures at edge S+MC+1,
  // unless Signal leaves 25 before edge S+MC inclusive.
  task automatic model_step();
    int age;
    cyc++;
    age = cyc - m_start;
    if (!rst_n) begin
      m_act = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_act) begin
      if (age <= MC && b.Signal != 6'd25) begin
        m_act = 1'b0;
      end else if (age == MC + 1) begin
        m_hi  = b.product[63:32];
        m_lo  = b.product[31:0];
        m_act = 1'b0;
      end
    end else if (b.mul_start && b.Signal == 6'd25) begin
      m_act   = 1'b1;
      m_start = cyc;
    end else if (b.Signal == 6'd17) begin
      m_hi = b.wr_data;
    end else if (b.Signal == 6'd19) begin
      m_lo = b.wr_data;
    end
  endtask

  task automatic compare_all();
    logic        e_done;
    logic [31:0] e_out;
    e_done = m_act && (cyc - m_start) == MC;
    e_out  = (b.Signal == 6'd16) ? m_hi :
             (b.Signal == 6'd18) ? m_lo : 32'h0;
    if (b.done === 1'b1) done_seen++;
    chk("hi", 64'(b.hi), 64'(m_hi));
    chk("lo", 64'(b.lo), 64'(m_lo));
    chk("busy", 64'(b.busy), 64'(m_act));
    chk("done", 64'(b.done), 64'(e_done));
    chk("rd_stall", 64'(b.rd_stall),
        64'(m_act && (b.Signal == 6'd16 || b.Signal == 6'd18)));
    chk("dataOut", 64'(b.dataOut), 64'(e_out));
  endtask

  task automatic cyc_drv(input logic [5:0] s, input logic st,
                         input logic r);
    b.Signal    = s;
    b.mul_start = st;
    rst_n       = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [63:0] p;
    logic [5:0]  codes [7];
    int          n;
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    cyc       = 0;
    m_start   = -1000;
    m_act     = 1'b0;
    m_hi      = '0;
    m_lo      = '0;
    b.product = '0;
    b.wr_data = '0;

    cyc_drv(6'd0, 1'b0, 1'b0);
    cyc_drv(6'd0, 1'b0, 1'b0);

    // Reset clears registers written by MTHI/MTLO.
    b.wr_data = 32'hDEAD_BEEF;
    cyc_drv(6'd17, 1'b0, 1'b1);
    cyc_drv(6'd19, 1'b0, 1'b1);
    chk("pre_rst_hi", 64'(b.hi), 64'h0000_0000_DEAD_BEEF);
    cyc_drv(6'd16, 1'b0, 1'b0);
    chk("rst_hi", 64'(b.hi), 64'h0);
    chk("rst_lo", 64'(b.lo), 64'h0);
    chk("rst_busy", 64'(b.busy), 64'h0);
    chk("rst_done", 64'(b.done), 64'h0);
    chk("rst_dout", 64'(b.dataOut), 64'h0);

    // Basic MULTU timing.
    b.product = 64'h0000_0002_FFFF_FFFE;
    cyc_drv(6'd25, 1'b1, 1'b1);
    chk("mul_busy0", 64'(b.busy), 64'h1);
    for (int k = 1; k <= MC + 1; k++) begin
      cyc_drv(6'd25, 1'b0, 1'b1);
      chk("mul_busy", 64'(b.busy), 64'(k <= MC));
      chk("mul_done", 64'(b.done), 64'(k == MC));
    end
    chk("mul_hi", 64'(b.hi), 64'h2);
    chk("mul_lo", 64'(b.lo), 64'hFFFF_FFFE);
    cyc_drv(6'd16, 1'b0, 1'b1);
    chk("mfhi", 64'(b.dataOut), 64'h2);
    cyc_drv(6'd18, 1'b0, 1'b1);
    chk("mflo", 64'(b.dataOut), 64'hFFFF_FFFE);

    // Read stall while in flight and during capture.
    b.wr_data = 32'h1234_5678;
    cyc_drv(6'd17, 1'b0, 1'b1);
    b.product = 64'hCAFE_0001_0000_0042;
    cyc_drv(6'd25, 1'b1, 1'b1);
    for (int k = 1; k <= MC; k++) begin
      cyc_drv(6'd25, 1'b0, 1'b1);
      if (k == 5) begin
        b.Signal = 6'd16;
        #1;
        chk("stall_run", 64'(b.rd_stall), 64'h1);
        chk("stall_old", 64'(b.dataOut), 64'h1234_5678);
        b.Signal = 6'd25;
      end
    end
    b.Signal = 6'd16;
    #1;
    chk("stall_cap", 64'(b.rd_stall), 64'h1);
    chk("stall_cap_old", 64'(b.dataOut), 64'h1234_5678);
    cyc_drv(6'd16, 1'b0, 1'b1);
    chk("stall_clr", 64'(b.rd_stall), 64'h0);
    chk("stall_new", 64'(b.dataOut), 64'hCAFE_0001);

    // Abort at count 10.
    b.wr_data = 32'h1111_1111;
    cyc_drv(6'd17, 1'b0, 1'b1);
    b.wr_data = 32'h2222_2222;
    cyc_drv(6'd19, 1'b0, 1'b1);
    b.product = 64'h9999_8888_7777_6666;
    done_seen = 0;
    cyc_drv(6'd25, 1'b1, 1'b1);
    for (int k = 1; k <= 11; k++) cyc_drv(6'd25, 1'b0, 1'b1);
    cyc_drv(6'd0, 1'b0, 1'b1);
    chk("abort_busy", 64'(b.busy), 64'h0);
    for (int k = 0; k < 3; k++) cyc_drv(6'd0, 1'b0, 1'b1);
    chk("abort_done", 64'(done_seen), 64'h0);
    chk("abort_hi", 64'(b.hi), 64'h1111_1111);
    chk("abort_lo", 64'(b.lo), 64'h2222_2222);

    // Reset at count 20, then a clean MULTU.
    done_seen = 0;
    cyc_drv(6'd25, 1'b1, 1'b1);
    for (int k = 1; k <= 21; k++) cyc_drv(6'd25, 1'b0, 1'b1);
    cyc_drv(6'd25, 1'b0, 1'b0);
    chk("mrst_busy", 64'(b.busy), 64'h0);
    chk("mrst_hi", 64'(b.hi), 64'h0);
    chk("mrst_lo", 64'(b.lo), 64'h0);
    chk("mrst_done", 64'(done_seen), 64'h0);
    b.product = 64'h0BAD_F00D_1357_9BDF;
    cyc_drv(6'd25, 1'b1, 1'b1);
    n = 0;
    while (b.hi !== 32'h0BAD_F00D && n < 40) begin
      cyc_drv(6'd25, 1'b0, 1'b1);
      n++;
    end
    chk("mrst_lat", 64'(n), 64'd33);
    chk("mrst_lo2", 64'(b.lo), 64'h1357_9BDF);

    // Restart attempt mid-flight and MTLO during capture.
    b.product = 64'h4444_3333_5555_6666;
    cyc_drv(6'd25, 1'b1, 1'b1);
    for (int k = 1; k <= MC; k++) begin
      cyc_drv(6'd25, k == 16, 1'b1);
      chk("rep_done", 64'(b.done), 64'(k == MC));
    end
    b.wr_data = 32'hA5A5_A5A5;
    cyc_drv(6'd19, 1'b0, 1'b1);
    chk("rep_hi", 64'(b.hi), 64'h4444_3333);
    chk("mtlo_busy", 64'(b.lo), 64'h5555_6666);
    cyc_drv(6'd19, 1'b0, 1'b1);
    chk("mtlo_idle", 64'(b.lo), 64'hA5A5_A5A5);

    // Randomized traffic.
    codes[0] = 6'd25; codes[1] = 6'd16; codes[2] = 6'd17;
    codes[3] = 6'd18; codes[4] = 6'd19; codes[5] = 6'd0;
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] s;
      codes[6]  = 6'($urandom);
      p         = {$urandom, $urandom};
      b.product = p;
      b.wr_data = $urandom;
      if (m_act && (cyc - m_start) < MC && $urandom_range(0, 149) != 0)
        s = 6'd25;
      else
        s = codes[$urandom_range(0, 6)];
      cyc_drv(s, $urandom_range(0, 3) == 0,
              $urandom_range(0, 199) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
